// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default widths for the serial bit feeder
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int DATA_W_DEFAULT = 8;
  localparam logic IDLE_BIT_DEFAULT = 1'b0;
endpackage

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word handshake (s_valid/s_ready/s_data), strobe bit_en, serial outputs out_bit/out_active/word_done/busy
interface serial_bit_feeder_if #(parameter int DATA_W = serial_pkg::DATA_W_DEFAULT);
  logic s_valid, s_ready, bit_en, out_bit, out_active, word_done, busy;
  logic [DATA_W-1:0] s_data;
  modport master(output s_valid, s_data, bit_en, input s_ready, out_bit, out_active, word_done, busy);
  modport slave(input s_valid, s_data, bit_en, output s_ready, out_bit, out_active, word_done, busy);
endinterface

// File: rtl/feeder_hold_reg.sv
// feeder_hold_reg: one-entry holding register; in_valid/in_ready/in_data load it, drain empties it, full/data expose it; clk, areset async high
module feeder_hold_reg
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              full,
  output logic [DATA_W-1:0] data
);
  logic full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    full_d = drain ? 1'b0 : full_q;
    data_d = data_q;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign in_ready = !full_q;
  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: serializes words from bus (s_valid/s_ready/s_data) onto bus.out_bit one per bus.bit_en, with out_active/word_done/busy status; clk, areset async high
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int   DATA_W    = DATA_W_DEFAULT,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT,
  parameter int   GAP_BITS  = 0
) (
  input logic clk,
  input logic areset,
  serial_bit_feeder_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  state_t state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, hold_data;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic word_done_q, word_done_d;
  logic hold_full, last_bit, gap_end, load;
  assign last_bit = state_q == SHIFT && bus.bit_en && bit_cnt_q == BIT_LAST;
  assign gap_end = state_q == GAP && bus.bit_en && gap_cnt_q == GAP_LAST;
  assign load = hold_full && (state_q == IDLE || (last_bit && GAP_BITS == 0) || gap_end);
  feeder_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk(clk),
    .areset(areset),
    .in_valid(bus.s_valid),
    .in_ready(bus.s_ready),
    .in_data(bus.s_data),
    .drain(load),
    .full(hold_full),
    .data(hold_data)
  );
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    word_done_d = last_bit;
    if (state_q == SHIFT && bus.bit_en) begin
      shreg_d = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (state_q == GAP && bus.bit_en) gap_cnt_d = gap_cnt_q + 8'd1;
    if (last_bit) begin
      state_d = GAP_BITS > 0 ? GAP : IDLE;
      gap_cnt_d = '0;
    end
    if (gap_end) state_d = IDLE;
    if (load) begin
      state_d = SHIFT;
      shreg_d = hold_data;
      bit_cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      word_done_q <= word_done_d;
    end
  end
  assign bus.out_active = state_q == SHIFT;
  assign bus.out_bit = state_q == SHIFT ? (MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0]) : IDLE_BIT;
  assign bus.word_done = word_done_q;
  assign bus.busy = state_q != IDLE || hold_full;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: table-driven and scoreboard checks of serial_bit_feeder with GAP_BITS 0 and 3
module tb_serial_bit_feeder;
  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;
  serial_bit_feeder_if #(.DATA_W(8)) bus[2] ();
  serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_BITS(0)) dut0 (
    .clk(clk), .areset(areset), .bus(bus[0]));
  serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_BITS(3)) dut1 (
    .clk(clk), .areset(areset), .bus(bus[1]));
  logic [1:0] sv = 2'b00;
  logic [7:0] sd[2];
  logic bit_en = 1'b1, mode = 1'b0, sync = 1'b0;
  logic [1:0] rdy, ob, oa, wd, bz;
  for (genvar g = 0; g < 2; g++) begin : gl
    assign bus[g].s_valid = sv[g];
    assign bus[g].s_data = sd[g];
    assign bus[g].bit_en = bit_en;
    assign rdy[g] = bus[g].s_ready;
    assign ob[g] = bus[g].out_bit;
    assign oa[g] = bus[g].out_active;
    assign wd[g] = bus[g].word_done;
    assign bz[g] = bus[g].busy;
  end
  int errors = 0, checks = 0, cyc = 0;
  int dones[2], popped[2], act_len[2], act_cnt[2], idle_cnt[2], spacing[2], last_done[2];
  bit tracking[2];
  logic q[2][$];
  typedef struct {logic [7:0] data; logic [7:0] ser; logic tog; int len;} vec_t;
  vec_t vecs[5];
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  task automatic tick();
    @(negedge clk);
    if (!areset) for (int g = 0; g < 2; g++) begin
      if (wd[g]) begin
        dones[g]++;
        act_len[g] = act_cnt[g];
        act_cnt[g] = 0;
        spacing[g] = cyc - last_done[g];
        last_done[g] = cyc;
        tracking[g] = 1'b1;
        idle_cnt[g] = 0;
      end
      if (tracking[g] && !bz[g]) tracking[g] = 1'b0;
      if (tracking[g] && !oa[g] && bit_en) idle_cnt[g]++;
      if (tracking[g] && oa[g]) begin
        chk("gap_idle_strobes", idle_cnt[g], g == 0 ? 0 : 3);
        tracking[g] = 1'b0;
      end
      if (!oa[g]) chk("idle_level", int'(ob[g]), 0);
      if (oa[g] && bit_en) begin
        if (q[g].size() == 0) chk("unexpected_bit", 1, 0);
        else chk("serial_bit", int'(ob[g]), int'(q[g].pop_front()));
        popped[g]++;
      end
      if (oa[g]) act_cnt[g]++;
      if (!rdy[g]) chk("ready_low_implies_busy", int'(bz[g]), 1);
    end
    @(posedge clk);
    cyc++;
    #1;
    bit_en = sync ? 1'b1 : (mode ? ~bit_en : 1'b1);
    sync = 1'b0;
  endtask
  task automatic send(input int g, input logic [7:0] d, input logic [7:0] ser);
    int n = 0;
    sv[g] = 1'b1;
    sd[g] = d;
    while (!rdy[g] && n < 200) begin
      tick();
      n++;
    end
    if (!rdy[g]) begin
      chk("accept_timeout", 0, 1);
      sv[g] = 1'b0;
      return;
    end
    for (int i = 7; i >= 0; i--) q[g].push_back(ser[i]);
    tick();
    chk("ready_after_accept", int'(rdy[g]), 0);
  endtask
  task automatic wait_done(input int g, input int target);
    int n = 0;
    while (dones[g] < target && n < 300) begin
      tick();
      n++;
    end
    chk("word_done_count", dones[g], target);
  endtask
  initial begin
    int d, p0, n;
    vecs[0] = '{8'b1101_0011, 8'b1101_0011, 1'b0, 8};
    vecs[1] = '{8'h5A, 8'b0101_1010, 1'b1, 16};
    vecs[2] = '{8'h00, 8'b0000_0000, 1'b0, 8};
    vecs[3] = '{8'hFF, 8'b1111_1111, 1'b0, 8};
    vecs[4] = '{8'h81, 8'b1000_0001, 1'b1, 16};
    for (int g = 0; g < 2; g++) begin
      sd[g] = 8'h00;
      dones[g] = 0; popped[g] = 0; act_len[g] = 0; act_cnt[g] = 0;
      idle_cnt[g] = 0; spacing[g] = 0; last_done[g] = 0; tracking[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_s_ready", int'(rdy[g]), 1);
      chk("reset_out_bit", int'(ob[g]), 0);
      chk("reset_out_active", int'(oa[g]), 0);
      chk("reset_busy", int'(bz[g]), 0);
    end
    tick();
    tick();
    areset = 1'b0;
    tick();
    foreach (vecs[i]) begin
      mode = vecs[i].tog;
      sync = 1'b1;
      d = dones[0];
      send(0, vecs[i].data, vecs[i].ser);
      sv[0] = 1'b0;
      wait_done(0, d + 1);
      chk("active_cycles", act_len[0], vecs[i].len);
      tick();
      tick();
      chk("after_word_busy", int'(bz[0]), 0);
      chk("after_word_ready", int'(rdy[0]), 1);
    end
    mode = 1'b0;
    tick();
    d = dones[0];
    send(0, 8'hFF, 8'b1111_1111);
    send(0, 8'h00, 8'b0000_0000);
    sv[0] = 1'b0;
    wait_done(0, d + 2);
    chk("b2b_done_spacing", spacing[0], 8);
    chk("b2b_active_cycles", act_len[0], 8);
    d = dones[1];
    send(1, 8'h3C, 8'b0011_1100);
    send(1, 8'hC5, 8'b1100_0101);
    send(1, 8'h96, 8'b1001_0110);
    sv[1] = 1'b0;
    wait_done(1, d + 3);
    chk("gap_done_spacing", spacing[1], 11);
    tick();
    tick();
    tick();
    tick();
    chk("queue0_drained", q[0].size(), 0);
    chk("queue1_drained", q[1].size(), 0);
    chk("gap_idle_busy", int'(bz[1]), 0);
    p0 = popped[0];
    send(0, 8'hA5, 8'b1010_0101);
    sv[0] = 1'b0;
    n = 0;
    while (popped[0] < p0 + 3 && n < 100) begin
      tick();
      n++;
    end
    chk("bits_before_reset", popped[0] - p0, 3);
    areset = 1'b1;
    #1;
    chk("midword_reset_s_ready", int'(rdy[0]), 1);
    chk("midword_reset_out_bit", int'(ob[0]), 0);
    chk("midword_reset_out_active", int'(oa[0]), 0);
    chk("midword_reset_busy", int'(bz[0]), 0);
    q[0].delete();
    act_cnt[0] = 0;
    tracking[0] = 1'b0;
    d = dones[0];
    tick();
    tick();
    areset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("no_done_after_reset", dones[0], d);
    chk("post_reset_busy", int'(bz[0]), 0);
    chk("post_reset_out_active", int'(oa[0]), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
